// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//
// Mode-0 (CPOL=0, CPHA=0), MSB-first, 8-bit SPI responder. It shares `clk`
// with the SPI master, so the SPI pins are only registered once. They are not
// synchronised against metastability.
//
// Each frame does three things:
//   - shifts `mosi` into a receive register;
//   - returns the byte preloaded from `tx_data` on `miso`;
//   - ends with a one-cycle `rx_valid` pulse.
// A deselect before the 8th bit, or any `sck` rise after the 8th bit, gives a
// one-cycle `frame_err` pulse.
//
// Ports
//   clk        in   1  system clock, shared with the master (rising edge)
//   rst_n      in   1  asynchronous active-low reset
//   sck        in   1  SPI clock from the master, idles low
//   mosi       in   1  serial data from the master
//   cs         in   1  chip select, active low
//   miso       out  1  serial data to the master (0 while in HOLD)
//   tx_data    in   8  byte returned during the next frame
//   rx_data    out  8  last complete byte received
//   rx_valid   out  1  one-cycle pulse when rx_data updates
//   busy       out  1  high while a frame is being shifted
//   frame_err  out  1  one-cycle pulse on an aborted frame or an extra sck rise
// -----------------------------------------------------------------------------
module spi_slave (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck,
  input  logic       mosi,
  input  logic       cs,
  output logic       miso,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic        cs_q;
  logic        mosi_q;
  logic        sck_q;
  logic        sck_qq;
  logic        sck_rise;
  logic [2:0]  bit_cnt;
  logic [7:0]  tx_sh;
  logic [7:0]  rx_sh;

  // ---- input stage: one register per pin, plus sck history for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q   <= 1'b0;
      mosi_q <= 1'b0;
      sck_q  <= 1'b0;
      sck_qq <= 1'b0;
    end else begin
      cs_q   <= cs;
      mosi_q <= mosi;
      sck_q  <= sck;
      sck_qq <= sck_q;
    end
  end

  assign sck_rise = sck_q & ~sck_qq;

  // miso is taken straight from the shift register. The shift happens two
  // clocks after the master's sck rise, so the next bit is already stable
  // when the master samples again three or more clocks later.
  assign miso = ((state == IDLE) || (state == SHIFT)) ? tx_sh[7] : 1'b0;

  // ---- frame control and shift registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Starting in HOLD means a frame already running at reset release is
      // ignored until the master deselects.
      state     <= HOLD;
      bit_cnt   <= 3'd0;
      tx_sh     <= 8'h00;
      rx_sh     <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        IDLE: begin
          // Keep tracking tx_data until the frame starts, so bit 7 is
          // already on miso before the first sck rise.
          tx_sh   <= tx_data;
          bit_cnt <= 3'd0;
          if (!cs_q) begin
            state <= SHIFT;
            busy  <= 1'b1;
            rx_sh <= 8'h00;
          end
        end

        SHIFT: begin
          if (cs_q) begin
            // A deselect mid-frame wins over a coincident sck rise. The
            // partial byte is dropped.
            frame_err <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
            bit_cnt   <= 3'd0;
            rx_sh     <= 8'h00;
          end else if (sck_rise) begin
            rx_sh   <= {rx_sh[6:0], mosi_q};
            tx_sh   <= {tx_sh[6:0], 1'b0};
            // Wraps 7 -> 0 on the completing bit.
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data  <= {rx_sh[6:0], mosi_q};
              rx_valid <= 1'b1;
              state    <= HOLD;
              busy     <= 1'b0;
            end
          end
        end

        HOLD: begin
          // The byte is complete. Any further sck rise is a protocol error,
          // and no data register changes here.
          if (sck_rise) begin
            frame_err <= 1'b1;
          end
          if (cs_q) begin
            state <= IDLE;
          end
        end

        default: begin
          state   <= HOLD;
          busy    <= 1'b0;
          bit_cnt <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
//
// Bench for spi_slave. A behavioural SPI master drives every pin on the
// falling clk edge. It samples miso on the same falling edge where it raises
// sck. Each bit takes 4 clocks: mosi is set, then sck goes high for 2 clocks,
// then sck goes low.
//
// The scoreboard works like this:
//   - each full frame pushes its expected byte onto rx_q;
//   - a monitor pops rx_q on every rx_valid and compares it with rx_data;
//   - the monitor also counts rx_valid and frame_err pulses.
// -----------------------------------------------------------------------------
module tb_spi_slave;

  logic       clk;
  logic       rst_n;
  logic       sck;
  logic       mosi;
  logic       cs;
  logic       miso;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       frame_err;

  int n_run;
  int n_fail;
  int rv_cnt;
  int fe_cnt;
  logic [7:0] rx_q[$];

  spi_slave dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sck       (sck),
    .mosi      (mosi),
    .cs        (cs),
    .miso      (miso),
    .tx_data   (tx_data),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output monitor.
  always @(negedge clk) begin
    if (rst_n && rx_valid) begin
      rv_cnt++;
      check("rx_q_nonempty", (rx_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (rx_q.size() > 0) begin
        check("rx_data", {24'd0, rx_data}, {24'd0, rx_q.pop_front()});
      end
    end
    if (rst_n && frame_err) begin
      fe_cnt++;
    end
  end

  // Set tx_data while cs is still high, then select the slave. Leave room
  // for the IDLE->SHIFT transition before the first sck rise.
  task automatic cs_low(input logic [7:0] tx);
    @(negedge clk);
    tx_data = tx;
    @(negedge clk);
    cs = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Transfer one bit. raise_cs deasserts cs together with the sck rise.
  task automatic bit_xfer(input logic b, output logic m, input logic raise_cs);
    @(negedge clk);
    mosi = b;
    @(negedge clk);
    m   = miso;
    sck = 1'b1;
    if (raise_cs) cs = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  // Full 8-bit frame. With extra set, a 9th sck pulse follows before deselect.
  // The frame ends with cs raised, so a following frame uses the minimum gap.
  task automatic frame(input logic [7:0] mo, input logic [7:0] tx, input logic extra);
    logic [7:0] rd;
    logic       m;
    rd = 8'h00;
    rx_q.push_back(mo);
    cs_low(tx);
    check("busy_on", {31'd0, busy}, 32'd1);
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(mo[i], m, 1'b0);
      rd[i] = m;
    end
    @(negedge clk);
    check("busy_off", {31'd0, busy}, 32'd0);
    if (extra) begin
      bit_xfer(1'b1, m, 1'b0);
      check("miso_extra", {31'd0, m}, 32'd0);
      @(negedge clk);
    end
    cs = 1'b1;
    check("master_rx", {24'd0, rd}, {24'd0, tx});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0;
    int rv0;
    logic m;
    logic [7:0] rd;

    n_run   = 0;
    n_fail  = 0;
    rv_cnt  = 0;
    fe_cnt  = 0;
    rst_n   = 1'b0;
    sck     = 1'b0;
    mosi    = 1'b0;
    cs      = 1'b1;
    tx_data = 8'h00;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_rx_data",   {24'd0, rx_data}, 32'h00);
    check("rst_rx_valid",  {31'd0, rx_valid}, 32'd0);
    check("rst_busy",      {31'd0, busy}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_miso",      {31'd0, miso}, 32'd0);
    rst_n = 1'b1;
    settle();

    // Basic frame.
    fe0 = fe_cnt; rv0 = rv_cnt;
    frame(8'hA5, 8'h3C, 1'b0);
    settle();
    check("a5_rv_cnt", rv_cnt - rv0, 32'd1);
    check("a5_fe_cnt", fe_cnt - fe0, 32'd0);

    // Back-to-back frames with the minimum cs gap.
    fe0 = fe_cnt; rv0 = rv_cnt;
    frame(8'h00, 8'hFF, 1'b0);
    frame(8'hFF, 8'h00, 1'b0);
    frame(8'h81, 8'h7E, 1'b0);
    settle();
    check("b2b_rv_cnt", rv_cnt - rv0, 32'd3);
    check("b2b_fe_cnt", fe_cnt - fe0, 32'd0);

    // Abort after 4 sck rises.
    fe0 = fe_cnt; rv0 = rv_cnt;
    cs_low(8'h11);
    for (int i = 0; i < 4; i++) bit_xfer(1'b1, m, 1'b0);
    @(negedge clk);
    cs = 1'b1;
    settle();
    check("abort_fe_cnt",  fe_cnt - fe0, 32'd1);
    check("abort_rv_cnt",  rv_cnt - rv0, 32'd0);
    check("abort_rx_data", {24'd0, rx_data}, 32'h81);
    frame(8'h5A, 8'hC7, 1'b0);
    settle();
    check("abort_next_rv", rv_cnt - rv0, 32'd1);

    // Extra 9th sck pulse while still selected.
    fe0 = fe_cnt; rv0 = rv_cnt;
    frame(8'h69, 8'hB4, 1'b1);
    settle();
    check("extra_rv_cnt", rv_cnt - rv0, 32'd1);
    check("extra_fe_cnt", fe_cnt - fe0, 32'd1);

    // Reset pulse after 3 bits with cs held low.
    cs_low(8'hE1);
    for (int i = 0; i < 3; i++) bit_xfer(1'b1, m, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rx_data",  {24'd0, rx_data}, 32'h00);
    check("mid_rst_busy",     {31'd0, busy}, 32'd0);
    check("mid_rst_miso",     {31'd0, miso}, 32'd0);
    check("mid_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    fe0 = fe_cnt; rv0 = rv_cnt;
    rd = 8'h00;
    for (int i = 0; i < 5; i++) begin
      bit_xfer(1'b1, m, 1'b0);
      rd[i] = m;
    end
    @(negedge clk);
    cs = 1'b1;
    settle();
    check("rst_rest_rv_cnt", rv_cnt - rv0, 32'd0);
    // Every rise while held in HOLD is an extra pulse.
    check("rst_rest_fe_cnt", fe_cnt - fe0, 32'd5);
    check("rst_rest_miso",   {24'd0, rd}, 32'h00);
    check("rst_rest_busy",   {31'd0, busy}, 32'd0);
    frame(8'hC3, 8'h96, 1'b0);
    settle();
    check("rst_next_rv", rv_cnt - rv0, 32'd1);

    // cs rises in the same cycle in which the 8th sck rise is detected.
    fe0 = fe_cnt; rv0 = rv_cnt;
    cs_low(8'h55);
    for (int i = 0; i < 7; i++) bit_xfer(1'b0, m, 1'b0);
    bit_xfer(1'b1, m, 1'b1);
    settle();
    check("coinc_fe_cnt",  fe_cnt - fe0, 32'd1);
    check("coinc_rv_cnt",  rv_cnt - rv0, 32'd0);
    check("coinc_rx_data", {24'd0, rx_data}, 32'hC3);
    check("coinc_busy",    {31'd0, busy}, 32'd0);

    // Recovery after the coincident abort.
    frame(8'h3E, 8'hD2, 1'b0);
    settle();
    check("coinc_next_rv", rv_cnt - rv0, 32'd1);
    check("rx_q_left", rx_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
